// File: rtl/pdm_stereo_modulator_if.sv
// ---------------------------------------------------------------------------
// pdm_stereo_modulator_if
//   Sample bus feeding the stereo PDM modulator.
//
//   Signals
//     lft_smpl   [15:0]  signed left sample, two's complement
//     rght_smpl  [15:0]  signed right sample, two's complement
//     smpl_vld           1-cycle strobe qualifying both samples
//
//   Handshake: valid-only. A transfer happens on every posedge where
//   smpl_vld=1; there is no ready, so the modulator accepts a strobe on
//   every cycle and the source never has to wait or hold data.
//
//   Modports
//     master : sample source (drives the bus)
//     slave  : modulator (samples the bus)
// ---------------------------------------------------------------------------
interface pdm_stereo_modulator_if;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        smpl_vld;

  modport master (output lft_smpl, output rght_smpl, output smpl_vld);
  modport slave  (input  lft_smpl, input  rght_smpl, input  smpl_vld);
endinterface

// File: rtl/pdm_stereo_modulator.sv
// ---------------------------------------------------------------------------
// pdm_stereo_modulator
//   Stereo first-order sigma-delta PDM modulator. Signed 16-bit samples are
//   offset to unsigned (0x8000 = silence) and accumulated; the carry out of
//   the 16-bit accumulator is the PDM bit, so ones density = u/65536.
//   A watchdog mutes both channels to silence when samples stop arriving.
//
//   Parameters
//     CLK_DIV    modulator steps once every CLK_DIV clk cycles
//     STALE_CYC  steps without smpl_vld before underrun mute
//
//   Ports
//     clk         system clock
//     RST_n       asynchronous reset, active-low
//     smpl_bus    sample bus (slave modport of pdm_stereo_modulator_if)
//     lft_PDM     left PDM bit,  lft_PDM_n  = ~lft_PDM  (same register stage)
//     rght_PDM    right PDM bit, rght_PDM_n = ~rght_PDM (same register stage)
//     underrun    high while muted because no samples are arriving
//     state_dbg   current FSM state (0 IDLE, 1 RUN, 2 STALE)
//
//   Build option
//     PDM_DITHER_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                    seed 0xACE1) adds a shared -8..+7 dither to u each step,
//                    saturated to 0x0000..0xFFFF. Undefined: bit-exact,
//                    deterministic first-order modulation.
// ---------------------------------------------------------------------------
module pdm_stereo_modulator #(
  parameter int CLK_DIV   = 1,
  parameter int STALE_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          RST_n,
  pdm_stereo_modulator_if.slave         smpl_bus,
  output logic                          lft_PDM,
  output logic                          lft_PDM_n,
  output logic                          rght_PDM,
  output logic                          rght_PDM_n,
  output logic                          underrun,
  output logic [1:0]                    state_dbg
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SC_W  = $clog2(STALE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_ctr;
  logic [SC_W-1:0]   stale_ctr;
  logic [15:0]       act_l, act_r;
  logic [15:0]       acc_l, acc_r;
  logic [15:0]       u_raw_l, u_raw_r;
  logic [15:0]       u_l, u_r;
  logic [16:0]       sum_l, sum_r;
  logic              step;
  logic              vld;
  logic              stale_hit;

  assign vld       = smpl_bus.smpl_vld;
  assign step      = (div_ctr == DIV_W'(CLK_DIV - 1));
  assign stale_hit = step && (stale_ctr == SC_W'(STALE_CYC - 1));

  // Only RUN feeds real audio; IDLE and STALE play silence (50% density)
  // while the accumulators keep their phase.
  always_comb begin
    u_raw_l = 16'h8000;
    u_raw_r = 16'h8000;
    if (state_q == RUN) begin
      u_raw_l = {~act_l[15], act_l[14:0]};
      u_raw_r = {~act_r[15], act_r[14:0]};
    end
  end

`ifdef PDM_DITHER_EN
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [4:0]         dith;
  logic signed [17:0] dith_ext;
  logic signed [17:0] ud_l, ud_r;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // {0,lfsr[3:0]} - 8 in 5-bit two's complement spans -8..+7.
  assign dith     = {1'b0, lfsr[3:0]} - 5'd8;
  assign dith_ext = {{13{dith[4]}}, dith};
  assign ud_l     = $signed({2'b00, u_raw_l}) + dith_ext;
  assign ud_r     = $signed({2'b00, u_raw_r}) + dith_ext;

  // Saturate so 0x7FFF/0x8000-extremes never wrap through the accumulator.
  always_comb begin
    u_l = ud_l[15:0];
    u_r = ud_r[15:0];
    if (ud_l[17])      u_l = 16'h0000;
    else if (ud_l[16]) u_l = 16'hFFFF;
    if (ud_r[17])      u_r = 16'h0000;
    else if (ud_r[16]) u_r = 16'hFFFF;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)    lfsr <= 16'hACE1;
    else if (step) lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign u_l = u_raw_l;
  assign u_r = u_raw_r;
`endif

  assign sum_l = {1'b0, acc_l} + {1'b0, u_l};
  assign sum_r = {1'b0, acc_r} + {1'b0, u_r};

  // Next-state logic. A strobe on the timeout step wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vld) state_d = RUN;
      RUN:     if (!vld && stale_hit) state_d = STALE;
      STALE:   if (vld) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)    div_ctr <= '0;
    else if (step) div_ctr <= '0;
    else           div_ctr <= div_ctr + DIV_W'(1);
  end

  // Counts steps since the last strobe while in RUN; saturates at STALE_CYC.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      stale_ctr <= '0;
    end else if (vld) begin
      stale_ctr <= '0;
    end else if (state_q == RUN && step && stale_ctr != SC_W'(STALE_CYC)) begin
      stale_ctr <= stale_ctr + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      act_l <= '0;
      act_r <= '0;
    end else if (vld) begin
      act_l <= smpl_bus.lft_smpl;
      act_r <= smpl_bus.rght_smpl;
    end
  end

  // PDM and its complement come from the same edge so they never skew.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      acc_l      <= '0;
      acc_r      <= '0;
      lft_PDM    <= 1'b0;
      lft_PDM_n  <= 1'b1;
      rght_PDM   <= 1'b0;
      rght_PDM_n <= 1'b1;
    end else if (step) begin
      acc_l      <= sum_l[15:0];
      acc_r      <= sum_r[15:0];
      lft_PDM    <= sum_l[16];
      lft_PDM_n  <= ~sum_l[16];
      rght_PDM   <= sum_r[16];
      rght_PDM_n <= ~sum_r[16];
    end
  end

  assign underrun  = (state_q == STALE);
  assign state_dbg = state_q;

endmodule
